alu_pipe: RTL and testbench
===========================

# alu_pipe

- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Executes the base opcode set (ADD … SLTU) with a registered result and real signed-overflow and carry flags.
- Adds unsigned divide/remainder, computed by an iterative restoring divider.
- Sits between issue and writeback in the execute stage; valid/ready on both sides lets it stall the pipe while a divide is in flight.

## Interface
- `WIDTH`, 32: operand/result width; legal range 8–64.
- `SHW`, $clog2(WIDTH): shift-amount width, taken from `B[SHW-1:0]`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand/opcode presented.
- `in_ready` out 1: block accepts the operation this cycle.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `Opcode` in 4: operation select.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer takes the result this cycle.
- `Q` out WIDTH: result.
- `Zero` out 1: flag, Q == 0.
- `Neg` out 1: flag, Q[WIDTH-1].
- `Overflow` out 1: signed overflow, ADD/SUB only.
- `Carry` out 1: carry out / no-borrow, ADD/SUB only.

## Operation
- **Opcodes:**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA (shift by `B[SHW-1:0]`).
  - 8 SLT (signed), 9 SLTU (unsigned); both produce `Q = {WIDTH-1 zeros, result}`.
  - 10 DIVU, 11 REMU.
  - 12–15: Q = 0, all flags 0.
- **ADD:** `{Carry,Q} = A + B` at WIDTH+1 bits. Overflow = (A[msb] == B[msb]) && (Q[msb] != A[msb]).
- **SUB:** `Q = A - B`. Carry = (A >= B) unsigned, i.e. no borrow. Overflow = (A[msb] != B[msb]) && (Q[msb] != A[msb]).
- **Other opcodes:** Overflow = 0, Carry = 0. Zero and Neg are always derived from the registered Q.
- **State machine:** IDLE, BUSY, HOLD.
  - `in_ready = !rst && (state == IDLE || (state == HOLD && out_ready))`.
  - `out_valid = (state == HOLD)`.
  - Accept occurs when `in_valid && in_ready`.
  - Accepting a single-cycle op (0–9, 12–15) goes to HOLD; Q and flags are registered from A/B that cycle.
  - Accepting DIVU/REMU with B != 0 goes to BUSY: A, B and the opcode are latched, the remainder register is cleared, and the iteration counter is set to WIDTH.
  - Accepting DIVU/REMU with B == 0 goes straight to HOLD:
    - DIVU: Q = all ones.
    - REMU: Q = A.
  - **BUSY:** one restoring-division step per cycle, MSB first, counter decrements. When the counter reaches 0, go to HOLD with Q = quotient (DIVU) or remainder (REMU), Overflow = Carry = 0.
  - **HOLD:**
    - `out_ready` with no new accept → IDLE.
    - `out_ready` with a new accept → same transitions as from IDLE. Back-to-back issue is allowed.
    - `!out_ready` → stay; Q and flags held stable.
- BUSY ignores `in_valid` (`in_ready` = 0). A and B may change freely during BUSY.

## Timing
- **Reset:** state IDLE, `out_valid` 0, Q 0, Zero 0, Neg 0, Overflow 0, Carry 0, counter 0.
- `rst` mid-divide or in HOLD aborts immediately; the result is discarded.
- **Single-cycle op:** accepted at edge t, `out_valid` = 1 from cycle t+1. Throughput is 1 op/cycle while `out_ready` = 1.
- **Divide, B != 0:** accepted at edge t, `out_valid` = 1 from cycle t+WIDTH+1.
- **Divide, B == 0:** latency 1.
- Q and flags change only on the edge leaving IDLE, BUSY→HOLD, or HOLD with `out_ready` and a new accept.
- No combinational path from A, B or Opcode to any output. `in_ready` depends combinationally on `out_ready`.

## Configuration
- **`ALU_DIV_EN` defined:** the divider, counter and BUSY state are compiled in; opcodes 10/11 behave as above.
- **`ALU_DIV_EN` undefined:** no divider logic; BUSY is unreachable. Opcodes 10/11 complete in 1 cycle with Q = 0 and all flags 0, identical to 12–15.

## Test plan
- **Overflow/Carry, WIDTH = 32, back-to-back, `out_ready` = 1:**
  - ADD 0x7FFFFFFF + 1 → Q = 0x80000000, Overflow 1, Carry 0, Neg 1.
  - ADD 0xFFFFFFFF + 1 → Q = 0, Zero 1, Carry 1, Overflow 0.
  - Pass: results on consecutive cycles.
- **Shifts and compares:**
  - SRA 0x80000000 by B = 0x21 → Q = 0xC0000000 (shamt 1).
  - SLT −1 < 1 → Q = 1.
  - SLTU 0xFFFFFFFF < 1 → Q = 0.
  - SUB 5 − 7 → Q = 0xFFFFFFFE, Carry 0, Neg 1.
- **DIVU 100 / 7 (`ALU_DIV_EN` defined):**
  - Q = 14 exactly 33 cycles after accept; `in_ready` = 0 throughout BUSY.
  - REMU 100 / 7 → Q = 2.
- **Divide by zero:**
  - DIVU 9 / 0 → Q = 0xFFFFFFFF.
  - REMU 9 / 0 → Q = 9.
  - Pass: both at latency 1.
- **Backpressure and reset:**
  - Hold `out_ready` = 0 for 5 cycles after ADD 3 + 4 → Q = 7 stable, `in_ready` 0; release → IDLE.
  - Assert `rst` at cycle 10 of a divide → next cycle `out_valid` 0, Q 0, `in_ready` 1 after release.
- **`ALU_DIV_EN` undefined:** DIVU 100 / 7 → Q = 0, all flags 0, latency 1.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake and data bundle between the issue stage, the
// pipelined ALU and the writeback stage.
//
// Signals
//   in_valid / in_ready : issue-side handshake (operation accepted when both high)
//   A, B, Opcode        : operands and operation select
//   out_valid/out_ready : writeback-side handshake (result consumed when both high)
//   Q                   : result
//   Zero, Neg           : result flags (Q == 0, Q[msb])
//   Overflow, Carry     : signed overflow and carry/no-borrow for ADD/SUB
//
// Modports
//   master : the issue/writeback side (drives operands and out_ready)
//   slave  : the ALU itself
interface alu_pipe_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       Opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Q;
    logic             Zero;
    logic             Neg;
    logic             Overflow;
    logic             Carry;

    modport master (
        output in_valid, A, B, Opcode, out_ready,
        input  in_ready, out_valid, Q, Zero, Neg, Overflow, Carry
    );

    modport slave (
        input  in_valid, A, B, Opcode, out_ready,
        output in_ready, out_valid, Q, Zero, Neg, Overflow, Carry
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: execute-stage ALU with valid/ready handshaking on both sides.
// Single-cycle ops (ADD..SLTU, 12-15) produce a registered result one cycle
// after accept.  Unsigned DIVU/REMU use an iterative restoring divider
// (one quotient bit per cycle, MSB first) and stall the issue side while busy.
//
// Build option
//   ALU_DIV_EN : when defined, the divider, its counter and the BUSY state are
//                compiled in.  When undefined, opcodes 10/11 behave like 12-15
//                (Q = 0, all flags 0, one-cycle latency).
//
// Ports
//   clk : clock, all state changes on the rising edge
//   rst : synchronous, active-high reset
//   bus : alu_pipe_if.slave (operands, result, flags, both handshakes)
//
// Parameters
//   WIDTH : operand/result width (8..64)
//   SHW   : shift-amount width, taken from B[SHW-1:0]
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             z;
        logic             n;
        logic             v;
        logic             c;
    } res_t;

    // Opcodes at or above this value produce Q = 0 with every flag forced low.
`ifdef ALU_DIV_EN
    localparam logic [3:0] FIRST_NULL_OP = 4'd12;
`else
    localparam logic [3:0] FIRST_NULL_OP = 4'd10;
`endif

    // Single-cycle result for one operation.  With the divider compiled in,
    // opcodes 10/11 only reach this path when B == 0.
    function automatic res_t alu_op(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [3:0]       op);
        res_t                    r;
        logic [WIDTH:0]          sum;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        r   = '0;
        sum = '0;
        sa  = signed'(a);
        sb  = signed'(b);
        case (op)
            4'd0: begin
                sum = {1'b0, a} + {1'b0, b};
                r.q = sum[WIDTH-1:0];
                r.c = sum[WIDTH];
                r.v = (a[WIDTH-1] == b[WIDTH-1]) && (r.q[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                r.q = a - b;
                r.c = (a >= b);
                r.v = (a[WIDTH-1] != b[WIDTH-1]) && (r.q[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:    r.q = a & b;
            4'd3:    r.q = a | b;
            4'd4:    r.q = a ^ b;
            4'd5:    r.q = a << b[SHW-1:0];
            4'd6:    r.q = a >> b[SHW-1:0];
            4'd7:    r.q = unsigned'(sa >>> b[SHW-1:0]);
            4'd8:    r.q = {{(WIDTH-1){1'b0}}, (sa < sb)};
            4'd9:    r.q = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_DIV_EN
            4'd10:   r.q = '1;
            4'd11:   r.q = a;
`endif
            default: r.q = '0;
        endcase
        if (op < FIRST_NULL_OP) begin
            r.z = (r.q == '0);
            r.n = r.q[WIDTH-1];
        end
        return r;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             div_start;
    logic             last;
    res_t             res_p0;
    logic [WIDTH-1:0] q_p1;
    logic             zero_p1;
    logic             neg_p1;
    logic             ovf_p1;
    logic             carry_p1;

    assign bus.in_ready  = !rst && (state == IDLE || (state == HOLD && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == HOLD);

    always_comb res_p0 = alu_op(bus.A, bus.B, bus.Opcode);

`ifdef ALU_DIV_EN
    localparam int CNTW = $clog2(WIDTH + 1);

    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] dvd_p1;
    logic [WIDTH-1:0] dvs_p1;
    logic [WIDTH-1:0] rem_p1;
    logic             op_rem_p1;
    logic [WIDTH:0]   rem_sh;
    logic             qbit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] div_q;

    assign div_start = (bus.Opcode == 4'd10 || bus.Opcode == 4'd11) && (bus.B != '0);
    assign last      = (state == BUSY) && (cnt == CNTW'(1));

    // Restoring step: shift the next dividend bit into the partial remainder;
    // the quotient bits fill the dividend register from the bottom.  The
    // subtraction is done at WIDTH bits because the true result is < divisor.
    always_comb begin
        rem_sh  = {rem_p1, dvd_p1[WIDTH-1]};
        qbit    = (rem_sh >= {1'b0, dvs_p1});
        rem_nxt = qbit ? (rem_sh[WIDTH-1:0] - dvs_p1) : rem_sh[WIDTH-1:0];
        quo_nxt = {dvd_p1[WIDTH-2:0], qbit};
        div_q   = op_rem_p1 ? rem_nxt : quo_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && div_start) begin
            cnt <= CNTW'(WIDTH);
        end else if (state == BUSY) begin
            cnt <= cnt - CNTW'(1);
        end
    end

    // ---- stage p1: divider working registers ----
    always_ff @(posedge clk) begin
        if (accept && div_start) begin
            dvd_p1    <= bus.A;
            dvs_p1    <= bus.B;
            rem_p1    <= '0;
            op_rem_p1 <= bus.Opcode[0];
        end else if (state == BUSY) begin
            dvd_p1 <= quo_nxt;
            rem_p1 <= rem_nxt;
        end
    end
`else
    assign div_start = 1'b0;
    assign last      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = div_start ? BUSY : HOLD;
            end
            BUSY: begin
                if (last) state_nxt = HOLD;
            end
            HOLD: begin
                if (accept)             state_nxt = div_start ? BUSY : HOLD;
                else if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p1: result and flag registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            q_p1     <= '0;
            zero_p1  <= 1'b0;
            neg_p1   <= 1'b0;
            ovf_p1   <= 1'b0;
            carry_p1 <= 1'b0;
        end else if (accept && !div_start) begin
            q_p1     <= res_p0.q;
            zero_p1  <= res_p0.z;
            neg_p1   <= res_p0.n;
            ovf_p1   <= res_p0.v;
            carry_p1 <= res_p0.c;
        end
`ifdef ALU_DIV_EN
        else if (last) begin
            q_p1     <= div_q;
            zero_p1  <= (div_q == '0);
            neg_p1   <= div_q[WIDTH-1];
            ovf_p1   <= 1'b0;
            carry_p1 <= 1'b0;
        end
`endif
    end

    assign bus.Q        = q_p1;
    assign bus.Zero     = zero_p1;
    assign bus.Neg      = neg_p1;
    assign bus.Overflow = ovf_p1;
    assign bus.Carry    = carry_p1;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH = 32.  Expected values are worked out
// by hand; flags are packed as {Zero, Neg, Overflow, Carry}.
module tb_alu_pipe;

    logic clk;
    logic rst;
    int   passes = 0;
    int   total  = 0;

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.Zero, bus.Neg, bus.Overflow, bus.Carry};
    endfunction

    // Issue at the current negedge, then check the result one cycle later.
    // in_valid is left high so consecutive calls issue back-to-back.
    task automatic run1(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [3:0] ef);
        check({tag, "_inrdy"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.Opcode   = op;
        bus.A        = a;
        bus.B        = b;
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_q"}, 64'(bus.Q), 64'(eq));
        check({tag, "_flags"}, 64'(flags()), 64'(ef));
    endtask

    // Issue one operation and measure latency (1 = result visible in the cycle
    // after the accepting edge), checking in_ready stays low while waiting.
    task automatic div_run(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [3:0] ef,
                           input int elat);
        int   lat;
        logic rdy_seen;
        check({tag, "_inrdy"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.Opcode   = op;
        bus.A        = a;
        bus.B        = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            bus.A = $urandom;
            bus.B = $urandom;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_busy_inrdy"}, 64'(rdy_seen), 64'd0);
        check({tag, "_q"}, 64'(bus.Q), 64'(eq));
        check({tag, "_flags"}, 64'(flags()), 64'(ef));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Opcode    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_q", 64'(bus.Q), 64'd0);
        check("rst_flags", 64'(flags()), 64'd0);
        check("rst_inrdy", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rel_inrdy", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Back-to-back single-cycle operations
        run1("add_ovf",   4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110);
        run1("add_carry", 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1001);
        run1("sra",       4'd7,  32'h80000000, 32'h00000021, 32'hC0000000, 4'b0100);
        run1("slt",       4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000);
        run1("sltu",      4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000);
        run1("sub_neg",   4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0100);
        run1("sub_ovf",   4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011);
        run1("sub_pos",   4'd1,  32'h00000007, 32'h00000005, 32'h00000002, 4'b0001);
        run1("and",       4'd2,  32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 4'b0000);
        run1("or",        4'd3,  32'hF0000000, 32'h0000000F, 32'hF000000F, 4'b0100);
        run1("xor",       4'd4,  32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 4'b1000);
        run1("sll",       4'd5,  32'h00000001, 32'h0000001F, 32'h80000000, 4'b0100);
        run1("srl",       4'd6,  32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000);
        run1("op13",      4'd13, 32'h00001234, 32'h00005678, 32'h00000000, 4'b0000);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("idle_valid", 64'(bus.out_valid), 64'd0);
        check("idle_inrdy", 64'(bus.in_ready), 64'd1);

        // Divide / remainder, including divide by zero
`ifdef ALU_DIV_EN
        div_run("divu",  4'd10, 32'd100, 32'd7, 32'd14,        4'b0000, 33);
        div_run("remu",  4'd11, 32'd100, 32'd7, 32'd2,         4'b0000, 33);
        div_run("divu0", 4'd10, 32'd9,   32'd0, 32'hFFFFFFFF,  4'b0100, 1);
        div_run("remu0", 4'd11, 32'd9,   32'd0, 32'd9,         4'b0000, 1);
`else
        div_run("divu",  4'd10, 32'd100, 32'd7, 32'd0, 4'b0000, 1);
        div_run("remu",  4'd11, 32'd100, 32'd7, 32'd0, 4'b0000, 1);
        div_run("divu0", 4'd10, 32'd9,   32'd0, 32'd0, 4'b0000, 1);
`endif
        @(negedge clk);
        check("div_idle_valid", 64'(bus.out_valid), 64'd0);

        // Backpressure: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        run1("bp_add", 4'd0, 32'd3, 32'd4, 32'd7, 4'b0000);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_q", 64'(bus.Q), 64'd7);
            check("bp_inrdy", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_rel_inrdy", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        check("bp_rel_valid", 64'(bus.out_valid), 64'd0);

        // Reset while holding a result
        bus.out_ready = 1'b0;
        run1("hold_add", 4'd0, 32'd2, 32'd2, 32'd4, 4'b0000);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("hold_rst_inrdy", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("hold_rst_valid", 64'(bus.out_valid), 64'd0);
        check("hold_rst_q", 64'(bus.Q), 64'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("hold_rst_inrdy_rel", 64'(bus.in_ready), 64'd1);

`ifdef ALU_DIV_EN
        // Reset in the middle of a divide
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Opcode   = 4'd10;
        bus.A        = 32'd100;
        bus.B        = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy_valid", 64'(bus.out_valid), 64'd0);
        check("mid_busy_inrdy", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_q", 64'(bus.Q), 64'd0);
        check("mid_rst_flags", 64'(flags()), 64'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_inrdy", 64'(bus.in_ready), 64'd1);
`endif

        // Normal operation resumes after reset
        @(negedge clk);
        run1("post_rst", 4'd0, 32'd1, 32'd2, 32'd3, 4'b0000);
        bus.in_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
